// File: rtl/mem_access_unit.sv
// Memory-stage data-memory controller: drives a ready-handshaked data port,
// forms byte enables and lane-aligned store data, formats load results
// (byte/half extension, LWL/LWR merge, SC status) and raises address errors.
module mem_access_unit #(
    parameter bit          LLSC_ENABLE    = 1'b1,
    parameter int unsigned USER_LIMIT_BIT = 31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        M_MemRead,
    input  logic        M_MemWrite,
    input  logic        M_MemByte,
    input  logic        M_MemHalf,
    input  logic        M_MemSignExtend,
    input  logic        M_Left,
    input  logic        M_Right,
    input  logic        M_LLSC,
    input  logic        M_ReverseEndian,
    input  logic        M_KernelMode,
    input  logic [31:0] M_Address,
    input  logic [31:0] M_WriteData,
    input  logic        M_Flush,
    input  logic        WB_Stall,
    input  logic        Eret,
    input  logic [31:0] DataMem_In,
    input  logic        DataMem_Ready,
    output logic        DataMem_Read,
    output logic [3:0]  DataMem_Write,
    output logic [29:0] DataMem_Address,
    output logic [31:0] DataMem_Out,
    output logic [31:0] M_ReadData,
    output logic        M_Stall,
    output logic        M_AdEL,
    output logic        M_AdES
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_llbit;
    logic [29:0] r_lladdr;
    logic [31:0] r_data;

    logic [1:0]  w_off;
    logic        w_word;
    logic        w_misalign;
    logic        w_priv_err;
    logic        w_ad_err;
    logic        w_sc;
    logic        w_sc_ok;
    logic        w_access;
    logic        w_req;
    logic        w_done;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_result;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // Lane offset, address checks and request qualification
    assign w_off      = M_Address[1:0] ^ {2{M_ReverseEndian}};
    assign w_word     = !M_MemByte && !M_MemHalf;
    assign w_misalign = (w_word && !M_Left && !M_Right && (M_Address[1:0] != 2'b00))
                      || (M_MemHalf && M_Address[0]);
    assign w_priv_err = !M_KernelMode && M_Address[USER_LIMIT_BIT];
    assign w_ad_err   = w_misalign || w_priv_err;
    assign w_sc       = M_MemWrite && M_LLSC;
    assign w_sc_ok    = LLSC_ENABLE && r_llbit && (r_lladdr == M_Address[31:2]);
    assign w_access   = (M_MemRead || (M_MemWrite && (!w_sc || w_sc_ok)))
                      && !w_ad_err && !M_Flush;
    // HOLD suppresses requests so a frozen EX/MEM cannot re-issue the access
    assign w_req      = !reset && (r_state != HOLD) && w_access;
    assign w_done     = w_req && DataMem_Ready;

    assign M_AdEL          = !reset && !M_Flush && M_MemRead  && w_ad_err;
    assign M_AdES          = !reset && !M_Flush && M_MemWrite && w_ad_err;
    assign M_Stall         = w_req && !DataMem_Ready;
    assign DataMem_Read    = w_req && M_MemRead;
    assign DataMem_Write   = (w_req && M_MemWrite) ? w_be : 4'b0000;
    assign DataMem_Address = reset ? 30'd0 : M_Address[31:2];
    assign DataMem_Out     = reset ? 32'd0 : w_wdata;
    assign M_ReadData      = reset ? 32'd0 : ((r_state == HOLD) ? r_data : w_result);

    // Load data alignment, extension and LWL/LWR merge
    always_comb begin
        w_byte = DataMem_In[31:24];
        w_load = DataMem_In;
        case (w_off)
            2'd0: w_byte = DataMem_In[31:24];
            2'd1: w_byte = DataMem_In[23:16];
            2'd2: w_byte = DataMem_In[15:8];
            default: w_byte = DataMem_In[7:0];
        endcase
        w_half = w_off[1] ? DataMem_In[15:0] : DataMem_In[31:16];
        if (M_Left) begin
            case (w_off)
                2'd0: w_load = DataMem_In;
                2'd1: w_load = {DataMem_In[23:0], M_WriteData[7:0]};
                2'd2: w_load = {DataMem_In[15:0], M_WriteData[15:0]};
                default: w_load = {DataMem_In[7:0], M_WriteData[23:0]};
            endcase
        end else if (M_Right) begin
            case (w_off)
                2'd3: w_load = DataMem_In;
                2'd2: w_load = {M_WriteData[31:24], DataMem_In[31:8]};
                2'd1: w_load = {M_WriteData[31:16], DataMem_In[31:16]};
                default: w_load = {M_WriteData[31:8], DataMem_In[31:24]};
            endcase
        end else if (M_MemByte) begin
            w_load = {{24{M_MemSignExtend && w_byte[7]}}, w_byte};
        end else if (M_MemHalf) begin
            w_load = {{16{M_MemSignExtend && w_half[15]}}, w_half};
        end
        w_result = 32'd0;
        if (M_MemRead)
            w_result = w_load;
        else if (w_sc && w_done)
            w_result = 32'd1;
    end

    // Store byte enables and lane-aligned write data
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = M_WriteData;
        if (M_Left) begin
            w_be    = 4'b1111 >> w_off;
            w_wdata = M_WriteData >> {w_off, 3'b000};
        end else if (M_Right) begin
            w_be    = 4'b1111 << (~w_off);
            w_wdata = M_WriteData << {~w_off, 3'b000};
        end else if (M_MemByte) begin
            w_be    = 4'b1000 >> w_off;
            w_wdata = {4{M_WriteData[7:0]}};
        end else if (M_MemHalf) begin
            w_be    = w_off[1] ? 4'b0011 : 4'b1100;
            w_wdata = {2{M_WriteData[15:0]}};
        end
    end

    // Next-state logic for the access handshake
    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE, BUSY: begin
                if (w_req) begin
                    if (DataMem_Ready)
                        w_state_nxt = WB_Stall ? HOLD : IDLE;
                    else
                        w_state_nxt = BUSY;
                end
            end
            HOLD: w_state_nxt = WB_Stall ? HOLD : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Held result and LL reservation; LL set takes priority over Eret
    always_ff @(posedge clock) begin
        if (reset) begin
            r_llbit  <= 1'b0;
            r_lladdr <= 30'd0;
            r_data   <= 32'd0;
        end else begin
            if (w_done && WB_Stall)
                r_data <= w_result;
            if (w_done && M_MemRead && M_LLSC && LLSC_ENABLE) begin
                r_llbit  <= 1'b1;
                r_lladdr <= M_Address[31:2];
            end else if (Eret || (w_done && w_sc)) begin
                r_llbit  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, LL/SC, address errors,
// wait-state stalls, WB_Stall hold, flush and reset while busy.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        M_MemRead, M_MemWrite, M_MemByte, M_MemHalf, M_MemSignExtend;
    logic        M_Left, M_Right, M_LLSC, M_ReverseEndian, M_KernelMode;
    logic [31:0] M_Address, M_WriteData;
    logic        M_Flush, WB_Stall, Eret;
    logic [31:0] DataMem_In;
    logic        DataMem_Ready;
    logic        DataMem_Read;
    logic [3:0]  DataMem_Write;
    logic [29:0] DataMem_Address;
    logic [31:0] DataMem_Out;
    logic [31:0] M_ReadData;
    logic        M_Stall, M_AdEL, M_AdES;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    mem_access_unit #(.LLSC_ENABLE(1'b1), .USER_LIMIT_BIT(31)) dut (
        .clock(clock), .reset(reset),
        .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .M_MemByte(M_MemByte),
        .M_MemHalf(M_MemHalf), .M_MemSignExtend(M_MemSignExtend),
        .M_Left(M_Left), .M_Right(M_Right), .M_LLSC(M_LLSC),
        .M_ReverseEndian(M_ReverseEndian), .M_KernelMode(M_KernelMode),
        .M_Address(M_Address), .M_WriteData(M_WriteData), .M_Flush(M_Flush),
        .WB_Stall(WB_Stall), .Eret(Eret), .DataMem_In(DataMem_In),
        .DataMem_Ready(DataMem_Ready), .DataMem_Read(DataMem_Read),
        .DataMem_Write(DataMem_Write), .DataMem_Address(DataMem_Address),
        .DataMem_Out(DataMem_Out), .M_ReadData(M_ReadData), .M_Stall(M_Stall),
        .M_AdEL(M_AdEL), .M_AdES(M_AdES)
    );

    task automatic clear_inputs();
        M_MemRead = 0; M_MemWrite = 0; M_MemByte = 0; M_MemHalf = 0;
        M_MemSignExtend = 0; M_Left = 0; M_Right = 0; M_LLSC = 0;
        M_ReverseEndian = 0; M_KernelMode = 1; M_Address = 32'h0;
        M_WriteData = 32'h0; M_Flush = 0; WB_Stall = 0; Eret = 0;
        DataMem_In = 32'h0; DataMem_Ready = 0;
    endtask

    // advance to just after the next rising edge; inputs are then driven
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        step();
        reset = 1; M_MemRead = 1; M_Address = 32'h100;
        #2;
        n_total++; if (DataMem_Read !== 1'b0) $display("FAIL reset_read: got %b exp 0", DataMem_Read); else n_pass++;
        n_total++; if (M_Stall !== 1'b0) $display("FAIL reset_stall: got %b exp 0", M_Stall); else n_pass++;
        n_total++; if (M_ReadData !== 32'h0) $display("FAIL reset_rdata: got %h exp 0", M_ReadData); else n_pass++;
        step();
        reset = 0; clear_inputs();
    endtask

    task automatic test_lb();
        step();
        M_MemRead = 1; M_MemByte = 1; M_MemSignExtend = 1; M_Address = 32'h1001;
        DataMem_In = 32'h11A2B344; DataMem_Ready = 1;
        #2;
        n_total++; if (M_ReadData !== 32'hFFFFFFA2) $display("FAIL lb_data: got %h exp ffffffa2", M_ReadData); else n_pass++;
        n_total++; if (M_Stall !== 1'b0) $display("FAIL lb_stall: got %b exp 0", M_Stall); else n_pass++;
        n_total++; if (DataMem_Read !== 1'b1) $display("FAIL lb_read: got %b exp 1", DataMem_Read); else n_pass++;
        n_total++; if (DataMem_Address !== 30'h400) $display("FAIL lb_addr: got %h exp 400", DataMem_Address); else n_pass++;
        step();
        clear_inputs();
    endtask

    task automatic test_sh_wait();
        int stalls = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            M_MemWrite = 1; M_MemHalf = 1; M_Address = 32'h2002;
            M_WriteData = 32'h0000BEEF; DataMem_Ready = (c == 3);
            #2;
            if (M_Stall === 1'b1) stalls++;
            if (c == 0) begin
                n_total++; if (DataMem_Write !== 4'b0011) $display("FAIL sh_be: got %b exp 0011", DataMem_Write); else n_pass++;
                n_total++; if (DataMem_Out !== 32'hBEEFBEEF) $display("FAIL sh_data: got %h exp beefbeef", DataMem_Out); else n_pass++;
            end
            if (c == 3) begin
                n_total++; if (DataMem_Write !== 4'b0011) $display("FAIL sh_be_done: got %b exp 0011", DataMem_Write); else n_pass++;
            end
        end
        n_total++; if (stalls != 3) $display("FAIL sh_stall_cycles: got %0d exp 3", stalls); else n_pass++;
        step();
        clear_inputs();
        #2;
        n_total++; if (M_Stall !== 1'b0) $display("FAIL sh_after: got %b exp 0", M_Stall); else n_pass++;
    endtask

    task automatic test_lwl_lwr();
        step();
        M_MemRead = 1; M_Left = 1; M_Address = 32'h3001;
        DataMem_In = 32'hAABBCCDD; M_WriteData = 32'h11223344; DataMem_Ready = 1;
        #2;
        n_total++; if (M_ReadData !== 32'hBBCCDD44) $display("FAIL lwl_data: got %h exp bbccdd44", M_ReadData); else n_pass++;
        n_total++; if (M_AdEL !== 1'b0) $display("FAIL lwl_adel: got %b exp 0", M_AdEL); else n_pass++;
        step();
        M_Left = 0; M_Right = 1;
        #2;
        n_total++; if (M_ReadData !== 32'h1122AABB) $display("FAIL lwr_data: got %h exp 1122aabb", M_ReadData); else n_pass++;
        step();
        clear_inputs();
    endtask

    task automatic test_addr_err();
        step();
        M_MemRead = 1; M_Address = 32'h4002; DataMem_Ready = 0;
        #2;
        n_total++; if (M_AdEL !== 1'b1) $display("FAIL adel_align: got %b exp 1", M_AdEL); else n_pass++;
        n_total++; if (DataMem_Read !== 1'b0) $display("FAIL adel_read: got %b exp 0", DataMem_Read); else n_pass++;
        n_total++; if (M_Stall !== 1'b0) $display("FAIL adel_stall: got %b exp 0", M_Stall); else n_pass++;
        step();
        M_Address = 32'h80000000; M_KernelMode = 0;
        #2;
        n_total++; if (M_AdEL !== 1'b1) $display("FAIL adel_user: got %b exp 1", M_AdEL); else n_pass++;
        step();
        M_KernelMode = 1;
        #2;
        n_total++; if (M_AdEL !== 1'b0) $display("FAIL adel_kernel: got %b exp 0", M_AdEL); else n_pass++;
        step();
        M_MemRead = 0; M_MemWrite = 1; M_Address = 32'h4001;
        #2;
        n_total++; if (M_AdES !== 1'b1) $display("FAIL ades_align: got %b exp 1", M_AdES); else n_pass++;
        n_total++; if (DataMem_Write !== 4'b0000) $display("FAIL ades_write: got %b exp 0000", DataMem_Write); else n_pass++;
        step();
        M_Flush = 1;
        #2;
        n_total++; if (M_AdES !== 1'b0) $display("FAIL ades_flush: got %b exp 0", M_AdES); else n_pass++;
        step();
        clear_inputs();
    endtask

    task automatic test_llsc();
        step();
        M_MemRead = 1; M_LLSC = 1; M_Address = 32'h5000; DataMem_In = 32'h1234; DataMem_Ready = 1;
        step();
        M_MemRead = 0; M_MemWrite = 1; M_WriteData = 32'hDEADBEEF;
        #2;
        n_total++; if (DataMem_Write !== 4'b1111) $display("FAIL sc_ok_be: got %b exp 1111", DataMem_Write); else n_pass++;
        n_total++; if (M_ReadData !== 32'd1) $display("FAIL sc_ok_status: got %h exp 1", M_ReadData); else n_pass++;
        step();
        #2;
        n_total++; if (DataMem_Write !== 4'b0000) $display("FAIL sc_rep_be: got %b exp 0000", DataMem_Write); else n_pass++;
        n_total++; if (M_ReadData !== 32'd0) $display("FAIL sc_rep_status: got %h exp 0", M_ReadData); else n_pass++;
        n_total++; if (M_Stall !== 1'b0) $display("FAIL sc_rep_stall: got %b exp 0", M_Stall); else n_pass++;
        step();
        M_MemWrite = 0; M_MemRead = 1;
        step();
        clear_inputs(); Eret = 1;
        step();
        Eret = 0; M_MemWrite = 1; M_LLSC = 1; M_Address = 32'h5000; DataMem_Ready = 1;
        #2;
        n_total++; if (DataMem_Write !== 4'b0000) $display("FAIL sc_eret_be: got %b exp 0000", DataMem_Write); else n_pass++;
        n_total++; if (M_ReadData !== 32'd0) $display("FAIL sc_eret_status: got %h exp 0", M_ReadData); else n_pass++;
        step();
        clear_inputs();
    endtask

    task automatic test_wb_stall();
        int reads = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            M_MemRead = 1; M_Address = 32'h6000; DataMem_Ready = 1;
            DataMem_In = (c == 0) ? 32'hCAFEF00D : 32'h55555555;
            WB_Stall = (c < 4);
            #2;
            if (DataMem_Read === 1'b1) reads++;
            n_total++; if (M_ReadData !== 32'hCAFEF00D) $display("FAIL wbs_data_c%0d: got %h exp cafef00d", c, M_ReadData); else n_pass++;
            n_total++; if (M_Stall !== 1'b0) $display("FAIL wbs_stall_c%0d: got %b exp 0", c, M_Stall); else n_pass++;
        end
        n_total++; if (reads != 1) $display("FAIL wbs_reads: got %0d exp 1", reads); else n_pass++;
        step();
        WB_Stall = 0; DataMem_Ready = 0;
        #2;
        n_total++; if (DataMem_Read !== 1'b1) $display("FAIL wbs_idle_read: got %b exp 1", DataMem_Read); else n_pass++;
        n_total++; if (M_Stall !== 1'b1) $display("FAIL wbs_idle_stall: got %b exp 1", M_Stall); else n_pass++;
        step();
        clear_inputs();
    endtask

    task automatic test_flush_busy();
        step();
        M_MemRead = 1; M_Address = 32'h6100; DataMem_Ready = 0;
        step();
        M_Flush = 1; DataMem_Ready = 1; DataMem_In = 32'h77777777;
        #2;
        n_total++; if (DataMem_Read !== 1'b0) $display("FAIL flush_read: got %b exp 0", DataMem_Read); else n_pass++;
        n_total++; if (M_Stall !== 1'b0) $display("FAIL flush_stall: got %b exp 0", M_Stall); else n_pass++;
        step();
        M_Flush = 0; DataMem_Ready = 0;
        #2;
        n_total++; if (M_Stall !== 1'b1) $display("FAIL flush_new_stall: got %b exp 1", M_Stall); else n_pass++;
        step();
        clear_inputs();
    endtask

    task automatic test_store_lanes();
        step();
        M_MemWrite = 1; M_MemByte = 1; M_ReverseEndian = 1; M_Address = 32'h7001;
        M_WriteData = 32'h0000005A; DataMem_Ready = 1;
        #2;
        n_total++; if (DataMem_Write !== 4'b0010) $display("FAIL sb_rev_be: got %b exp 0010", DataMem_Write); else n_pass++;
        n_total++; if (DataMem_Out !== 32'h5A5A5A5A) $display("FAIL sb_rev_data: got %h exp 5a5a5a5a", DataMem_Out); else n_pass++;
        step();
        M_MemByte = 0; M_ReverseEndian = 0; M_Left = 1; M_WriteData = 32'h11223344;
        #2;
        n_total++; if (DataMem_Write !== 4'b0111) $display("FAIL swl_be: got %b exp 0111", DataMem_Write); else n_pass++;
        n_total++; if (DataMem_Out !== 32'h00112233) $display("FAIL swl_data: got %h exp 00112233", DataMem_Out); else n_pass++;
        step();
        M_Left = 0; M_Right = 1;
        #2;
        n_total++; if (DataMem_Write !== 4'b1100) $display("FAIL swr_be: got %b exp 1100", DataMem_Write); else n_pass++;
        n_total++; if (DataMem_Out !== 32'h33440000) $display("FAIL swr_data: got %h exp 33440000", DataMem_Out); else n_pass++;
        n_total++; if (M_ReadData !== 32'h0) $display("FAIL store_rdata: got %h exp 0", M_ReadData); else n_pass++;
        step();
        clear_inputs();
        M_MemRead = 1; M_MemHalf = 1; M_Address = 32'h7002; DataMem_In = 32'h1234ABCD; DataMem_Ready = 1;
        #2;
        n_total++; if (M_ReadData !== 32'h0000ABCD) $display("FAIL lhu_data: got %h exp 0000abcd", M_ReadData); else n_pass++;
        step();
        clear_inputs();
    endtask

    task automatic test_reset_busy();
        step();
        M_MemRead = 1; M_Address = 32'h8000; DataMem_Ready = 0;
        step();
        reset = 1;
        #2;
        n_total++; if (DataMem_Read !== 1'b0) $display("FAIL rstb_read: got %b exp 0", DataMem_Read); else n_pass++;
        n_total++; if (M_Stall !== 1'b0) $display("FAIL rstb_stall: got %b exp 0", M_Stall); else n_pass++;
        step();
        reset = 0; clear_inputs();
        #2;
        n_total++; if (M_Stall !== 1'b0) $display("FAIL rstb_after: got %b exp 0", M_Stall); else n_pass++;
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_lb();
        test_sh_wait();
        test_lwl_lwr();
        test_addr_err();
        test_llsc();
        test_wb_stall();
        test_flush_busy();
        test_store_lanes();
        test_reset_busy();
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
